// File: rtl/apb_sram_pkg.sv
// Shared types and constants for the APB SRAM access path and its requester arbiter.
package apb_sram_pkg;

  localparam int ADDR_WIDTH      = 32;
  localparam int DATA_WIDTH      = 32;
  // Number of implemented SRAM words; addresses at or above this are out of range.
  localparam int PAGE_NUM        = 64;
  localparam int DEFAULT_NUM_REQ = 4;

  typedef logic [ADDR_WIDTH-1:0] apb_addr_t;
  typedef logic [DATA_WIDTH-1:0] apb_data_t;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_SETUP  = 2'd1,
    ARB_ACCESS = 2'd2
  } arb_state_t;

endpackage

// File: rtl/apb_sram_if.sv
// APB bus between the arbiter (master) and the SRAM bridge (slave).
interface apb_sram_if;
  import apb_sram_pkg::*;

  // Handshake: a transfer is SETUP (psel=1, penable=0) for one cycle, then ACCESS
  // (psel=1, penable=1) until the slave returns pready=1; prdata/pslverr are only
  // meaningful in that ACCESS cycle, and address/control stay stable throughout.
  logic      psel;
  logic      penable;
  apb_addr_t paddr;
  logic      pwrite;
  apb_data_t pwdata;
  apb_data_t prdata;
  logic      pready;
  logic      pslverr;

  modport master (
    output psel, penable, paddr, pwrite, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, paddr, pwrite, pwdata,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/rr_arbiter.sv
// Rotating-priority selector: the search starts one past the last accepted grant.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic               sram_gclk,
  input  logic               rstn,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               adv_i,
  output logic [NUM_REQ-1:0] gnt_o
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W+1)'(NUM_REQ);

  logic [IDX_W-1:0] last_q, last_d;
  logic [IDX_W:0]   cand;
  logic             found;

  always_comb begin
    gnt_o  = '0;
    last_d = last_q;
    found  = 1'b0;
    cand   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, last_q} + (IDX_W+1)'(i + 1);
      if (cand >= NUM_REQ_W) cand = cand - NUM_REQ_W;
      if (!found && req_i[cand[IDX_W-1:0]]) begin
        found                  = 1'b1;
        gnt_o[cand[IDX_W-1:0]] = 1'b1;
        last_d                 = cand[IDX_W-1:0];
      end
    end
  end

  // Reset to the last index so requester 0 is searched first.
  always_ff @(posedge sram_gclk) begin
    if (!rstn) begin
      last_q <= IDX_W'(NUM_REQ - 1);
    end else if (adv_i) begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/apb_sram_arbiter.sv
// Shares one APB SRAM port among NUM_REQ requesters; one transfer at a time with
// a registered one-cycle completion pulse and an ACCESS-phase timeout.
module apb_sram_arbiter
  import apb_sram_pkg::*;
#(
  parameter int NUM_REQ        = DEFAULT_NUM_REQ,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic               sram_gclk,
  input  logic               rstn,
  input  logic [NUM_REQ-1:0] req_valid_i,
  input  logic [NUM_REQ-1:0] req_write_i,
  input  apb_addr_t          req_addr_i  [NUM_REQ],
  input  apb_data_t          req_wdata_i [NUM_REQ],
  output logic [NUM_REQ-1:0] rsp_valid_o,
  output apb_data_t          rsp_rdata_o,
  output logic               rsp_err_o,
  output logic [NUM_REQ-1:0] grant_o,
  output arb_state_t         dbg_state_o,
  apb_sram_if.master         apb_if_m0
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  arb_state_t         state_q, state_d;
  apb_addr_t          addr_q, addr_d;
  apb_data_t          wdata_q, wdata_d;
  logic               write_q, write_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  apb_data_t          rsp_rdata_q, rsp_rdata_d;
  logic               rsp_err_q, rsp_err_d;

  logic [NUM_REQ-1:0] arb_req;
  logic [NUM_REQ-1:0] arb_gnt;
  logic               arb_adv;

  // The requester being answered this cycle is masked so it cannot win straight back.
  assign arb_req = req_valid_i & ~rsp_valid_q;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .sram_gclk (sram_gclk),
    .rstn      (rstn),
    .req_i     (arb_req),
    .adv_i     (arb_adv),
    .gnt_o     (arb_gnt)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    write_d     = write_q;
    grant_d     = grant_q;
    tmo_d       = tmo_q;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    arb_adv     = 1'b0;

    unique case (state_q)
      ARB_IDLE: begin
        if (|arb_gnt) begin
          arb_adv = 1'b1;
          grant_d = arb_gnt;
          state_d = ARB_SETUP;
          for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_gnt[i]) begin
              addr_d  = req_addr_i[i];
              wdata_d = req_wdata_i[i];
              write_d = req_write_i[i];
            end
          end
        end
      end

      ARB_SETUP: begin
        tmo_d   = '0;
        state_d = ARB_ACCESS;
      end

      ARB_ACCESS: begin
        if (apb_if_m0.pready) begin
          rsp_valid_d = grant_q;
          rsp_rdata_d = write_q ? '0 : apb_if_m0.prdata;
          rsp_err_d   = apb_if_m0.pslverr;
          grant_d     = '0;
          tmo_d       = '0;
          state_d     = ARB_IDLE;
        end else if (tmo_q == TMO_LAST) begin
          rsp_valid_d = grant_q;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          grant_d     = '0;
          tmo_d       = '0;
          state_d     = ARB_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      default: begin
        state_d = ARB_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge sram_gclk) begin
    if (!rstn) begin
      state_q     <= ARB_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      write_q     <= 1'b0;
      grant_q     <= '0;
      tmo_q       <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      write_q     <= write_d;
      grant_q     <= grant_d;
      tmo_q       <= tmo_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign apb_if_m0.psel    = (state_q != ARB_IDLE);
  assign apb_if_m0.penable = (state_q == ARB_ACCESS);
  assign apb_if_m0.paddr   = addr_q;
  assign apb_if_m0.pwrite  = write_q;
  assign apb_if_m0.pwdata  = wdata_q;

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign grant_o     = grant_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_apb_sram_arbiter.sv
// Bench for apb_sram_arbiter: SRAM slave model, scoreboard of expected responses and grants.
module tb_apb_sram_arbiter;
  import apb_sram_pkg::*;

  localparam int N   = 4;
  localparam int TMO = 16;
  localparam int RW  = N + DATA_WIDTH + 1;
  localparam int AW  = $clog2(PAGE_NUM);

  // ---------------- clock / reset ----------------
  logic sram_gclk = 1'b0;
  logic rstn      = 1'b0;
  always #5 sram_gclk = ~sram_gclk;

  logic [N-1:0] req_valid = '0;
  logic [N-1:0] req_write = '0;
  apb_addr_t    req_addr  [N];
  apb_data_t    req_wdata [N];
  logic [N-1:0] rsp_valid;
  apb_data_t    rsp_rdata;
  logic         rsp_err;
  logic [N-1:0] grant;
  arb_state_t   dbg_state;

  apb_sram_if apb ();

  apb_sram_arbiter #(
    .NUM_REQ        (N),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .sram_gclk   (sram_gclk),
    .rstn        (rstn),
    .req_valid_i (req_valid),
    .req_write_i (req_write),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .rsp_valid_o (rsp_valid),
    .rsp_rdata_o (rsp_rdata),
    .rsp_err_o   (rsp_err),
    .grant_o     (grant),
    .dbg_state_o (dbg_state),
    .apb_if_m0   (apb)
  );

  // ---------------- SRAM slave model ----------------
  apb_data_t slave_mem [PAGE_NUM];
  apb_data_t model_mem [PAGE_NUM];
  int unsigned ws_max  = 0;
  int unsigned ws_left = 0;
  bit          stall   = 1'b0;

  always_comb begin
    apb.pready  = apb.psel && apb.penable && (ws_left == 0) && !stall;
    apb.prdata  = '0;
    apb.pslverr = 1'b0;
    if (apb.pready) begin
      if (apb.paddr >= PAGE_NUM) apb.pslverr = 1'b1;
      else if (!apb.pwrite)      apb.prdata  = slave_mem[apb.paddr[AW-1:0]];
    end
  end

  always @(posedge sram_gclk) begin
    if (apb.psel && !apb.penable)                     ws_left <= $urandom_range(0, ws_max);
    else if (apb.psel && apb.penable && ws_left != 0) ws_left <= ws_left - 1;
    if (apb.pready && apb.pwrite && apb.paddr < PAGE_NUM)
      slave_mem[apb.paddr[AW-1:0]] <= apb.pwdata;
  end

  // ---------------- scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  logic [RW-1:0] exp_q [$];
  logic [N-1:0]  gnt_q [$];
  bit            mon_en = 1'b0;
  logic [RW-1:0] mon_e;
  logic [N-1:0]  prev_gnt = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int r);
    logic [N-1:0] v;
    v    = '0;
    v[r] = 1'b1;
    return v;
  endfunction

  task automatic push_exp(input int r, input apb_data_t d, input bit err);
    exp_q.push_back({onehot(r), d, err});
    gnt_q.push_back(onehot(r));
  endtask

  always @(negedge sram_gclk) begin
    if (mon_en) begin
      if (rsp_valid != '0) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected_pulse", 64'(rsp_valid), 64'(0));
        end else begin
          mon_e = exp_q.pop_front();
          chk("rsp_who",   64'(rsp_valid), 64'(mon_e[RW-1 -: N]));
          chk("rsp_rdata", 64'(rsp_rdata), 64'(mon_e[DATA_WIDTH:1]));
          chk("rsp_err",   64'(rsp_err),   64'(mon_e[0]));
        end
      end
      if (grant != '0 && prev_gnt == '0) begin
        if (gnt_q.size() == 0) chk("grant_unexpected", 64'(grant), 64'(0));
        else                   chk("grant_order", 64'(grant), 64'(gnt_q.pop_front()));
      end
      if (grant != '0 && prev_gnt != '0 && grant != prev_gnt)
        chk("grant_idle_gap", 64'(prev_gnt), 64'(0));
      prev_gnt <= grant;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_xfer(input int r, input bit wr, input apb_addr_t a, input apb_data_t d,
                         input bit scramble, input bit drop);
    apb_data_t er;
    bit        ee;
    int        k;
    ee = (a >= PAGE_NUM);
    er = '0;
    if (!ee && wr)  model_mem[a[AW-1:0]] = d;
    if (!ee && !wr) er = model_mem[a[AW-1:0]];
    push_exp(r, er, ee);
    req_write[r] = wr;
    req_addr[r]  = a;
    req_wdata[r] = d;
    req_valid[r] = 1'b1;
    k = 0;
    while (k < 20 && !grant[r]) begin
      @(negedge sram_gclk);
      k++;
    end
    if (!grant[r]) chk("grant_wait_expired", 64'(grant), 64'(onehot(r)));
    if (scramble) begin
      req_write[r] = ~wr;
      req_addr[r]  = $urandom;
      req_wdata[r] = $urandom;
    end
    if (drop) req_valid[r] = 1'b0;
    k = 0;
    while (k < 100 && !rsp_valid[r]) begin
      @(negedge sram_gclk);
      k++;
    end
    if (!rsp_valid[r]) chk("rsp_wait_expired", 64'(rsp_valid), 64'(onehot(r)));
    req_valid[r] = 1'b0;
    @(negedge sram_gclk);
  endtask

  // All requesters in mask read addr 8+i and each stays valid until its cnt-th pulse.
  task automatic run_conc(input logic [N-1:0] mask, input int cnt, input bit release_rst);
    int rem  [N];
    int seen [N];
    int last, total, done, k, c;
    last  = N - 1;
    total = 0;
    for (int i = 0; i < N; i++) begin
      rem[i]  = mask[i] ? cnt : 0;
      seen[i] = 0;
      total  += rem[i];
    end
    for (int g = 0; g < total; g++) begin
      for (int j = 1; j <= N; j++) begin
        c = (last + j) % N;
        if (rem[c] > 0) break;
      end
      rem[c]--;
      last = c;
      push_exp(c, model_mem[8 + c], 1'b0);
    end
    for (int i = 0; i < N; i++) begin
      req_addr[i]  = apb_addr_t'(8 + i);
      req_write[i] = 1'b0;
    end
    req_valid = mask;
    if (release_rst) rstn = 1'b1;
    done = 0;
    k    = 0;
    while (done < total && k < 300) begin
      @(negedge sram_gclk);
      k++;
      for (int i = 0; i < N; i++) begin
        if (rsp_valid[i]) begin
          seen[i]++;
          done++;
          if (seen[i] == cnt) req_valid[i] = 1'b0;
        end
      end
    end
    if (done < total) chk("conc_wait_expired", 64'(done), 64'(total));
    req_valid = '0;
    @(negedge sram_gclk);
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    repeat (2) @(negedge sram_gclk);
    rstn = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    int k, cnt;
    for (int i = 0; i < PAGE_NUM; i++) begin
      slave_mem[i] = apb_data_t'(i) * 32'h0101_0101 ^ 32'h3C5A_0000;
      model_mem[i] = slave_mem[i];
    end
    for (int i = 0; i < N; i++) begin
      req_addr[i]  = '0;
      req_wdata[i] = '0;
    end

    // Reset values
    rstn = 1'b0;
    repeat (2) @(negedge sram_gclk);
    chk("rst_psel",    64'(apb.psel),    64'(0));
    chk("rst_penable", 64'(apb.penable), 64'(0));
    chk("rst_paddr",   64'(apb.paddr),   64'(0));
    chk("rst_pwrite",  64'(apb.pwrite),  64'(0));
    chk("rst_pwdata",  64'(apb.pwdata),  64'(0));
    chk("rst_grant",   64'(grant),       64'(0));
    chk("rst_rsp",     64'(rsp_valid),   64'(0));
    chk("rst_rdata",   64'(rsp_rdata),   64'(0));
    chk("rst_err",     64'(rsp_err),     64'(0));
    chk("rst_state",   64'(dbg_state),   64'(ARB_IDLE));
    rstn   = 1'b1;
    mon_en = 1'b1;
    @(negedge sram_gclk);

    // Round-robin order from reset with everyone pending
    run_conc(4'b1111, 2, 1'b0);

    // Write 0xA5A5A5A5 to addr 5, then a zero-wait read by requester 1 with exact timing
    ws_max = 0;
    do_xfer(2, 1'b1, 32'h5, 32'hA5A5_A5A5, 1'b0, 1'b0);
    push_exp(1, model_mem[5], 1'b0);
    req_write[1] = 1'b0;
    req_addr[1]  = 32'h5;
    req_valid[1] = 1'b1;
    @(negedge sram_gclk);
    chk("rd_setup_psel",    64'(apb.psel),    64'(1));
    chk("rd_setup_penable", 64'(apb.penable), 64'(0));
    chk("rd_setup_grant",   64'(grant),       64'(4'b0010));
    @(negedge sram_gclk);
    chk("rd_access_psel",    64'(apb.psel),    64'(1));
    chk("rd_access_penable", 64'(apb.penable), 64'(1));
    chk("rd_access_paddr",   64'(apb.paddr),   64'(5));
    @(negedge sram_gclk);
    chk("rd_lat3_pulse", 64'(rsp_valid), 64'(4'b0010));
    chk("rd_lat3_rdata", 64'(rsp_rdata), 64'(32'hA5A5_A5A5));
    chk("rd_idle_psel",  64'(apb.psel),  64'(0));
    req_valid[1] = 1'b0;
    @(negedge sram_gclk);

    // Out-of-range address errors, the following legal access does not
    do_xfer(3, 1'b0, apb_addr_t'(PAGE_NUM + 3), 32'h0, 1'b0, 1'b0);
    do_xfer(3, 1'b0, 32'h7, 32'h0, 1'b0, 1'b0);
    do_xfer(0, 1'b1, apb_addr_t'(PAGE_NUM), 32'hDEAD_BEEF, 1'b0, 1'b0);

    // Randomized serial traffic with wait states, late input changes and early drops
    ws_max = 3;
    for (int t = 0; t < 40; t++) begin
      int        r;
      bit        wr;
      apb_addr_t a;
      r  = int'($urandom_range(0, N - 1));
      wr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) a = apb_addr_t'(PAGE_NUM + int'($urandom_range(0, 15)));
      else                           a = apb_addr_t'($urandom_range(0, PAGE_NUM - 1));
      do_xfer(r, wr, a, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
    end

    // Timeout: PREADY never comes
    stall = 1'b1;
    push_exp(2, '0, 1'b1);
    req_write[2] = 1'b0;
    req_addr[2]  = 32'h9;
    req_valid[2] = 1'b1;
    cnt = 0;
    k   = 0;
    while (k < 100 && !rsp_valid[2]) begin
      @(negedge sram_gclk);
      k++;
      if (apb.penable) cnt++;
    end
    chk("tmo_access_cycles", 64'(cnt),      64'(TMO));
    chk("tmo_psel_low",      64'(apb.psel), 64'(0));
    req_valid[2] = 1'b0;
    stall        = 1'b0;
    @(negedge sram_gclk);

    // Reset during ACCESS: no pulse, pointer back to requester 0
    ws_max = 0;
    do_xfer(0, 1'b0, 32'h1, 32'h0, 1'b0, 1'b0);
    stall = 1'b1;
    gnt_q.push_back(onehot(1));
    req_write[1] = 1'b0;
    req_addr[1]  = 32'h3;
    req_valid[1] = 1'b1;
    k = 0;
    while (k < 20 && !apb.penable) begin
      @(negedge sram_gclk);
      k++;
    end
    chk("abort_in_access", 64'(apb.penable), 64'(1));
    repeat (2) @(negedge sram_gclk);
    rstn = 1'b0;
    @(negedge sram_gclk);
    chk("abort_psel",    64'(apb.psel),    64'(0));
    chk("abort_penable", 64'(apb.penable), 64'(0));
    chk("abort_grant",   64'(grant),       64'(0));
    chk("abort_rsp",     64'(rsp_valid),   64'(0));
    chk("abort_paddr",   64'(apb.paddr),   64'(0));
    chk("abort_state",   64'(dbg_state),   64'(ARB_IDLE));
    req_valid[1] = 1'b0;
    stall        = 1'b0;
    run_conc(4'b0101, 1, 1'b1);

    repeat (5) @(negedge sram_gclk);
    chk("exp_q_drained", 64'(exp_q.size()), 64'(0));
    chk("gnt_q_drained", 64'(gnt_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
